ifetch: RTL

Instruction fetch unit: the initiator on the instruction-memory read port (addr/word/cs/data). It owns the PC and issues one fetch per cycle. It detects 16-bit compressed vs 32-bit RISC-V instructions and hands them to decode over a valid/ready handshake. It also handles branch/jump redirects and halts on fetch faults.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_if.sv | 27 ++
 rtl/ifetch_len.sv | 27 ++
 rtl/ifetch.sv | 98 +++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and encodings for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [1:0] WORD_B  = 2'b00;
  localparam logic [1:0] WORD_H  = 2'b01;
  localparam logic [1:0] WORD_W  = 2'b10;
  localparam logic [1:0] WORD_D  = 2'b11;

  localparam logic [1:0] ILEN_32 = 2'b11;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory read port plus the fetch-to-decode valid/ready handshake.
interface ifetch_if #(
  parameter int XLEN = 64,
  parameter int AW   = 10
);
  logic [AW-1:0]   imem_addr;
  logic [1:0]      imem_word;
  logic            imem_cs;
  logic [63:0]     imem_data;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_c_o;
  logic            inst_valid_o;
  logic            inst_ready_i;

  modport master (
    output imem_addr, imem_word, imem_cs,
    output inst_o, inst_pc_o, inst_c_o, inst_valid_o,
    input  imem_data, inst_ready_i
  );

  modport slave (
    input  imem_addr, imem_word, imem_cs,
    input  inst_o, inst_pc_o, inst_c_o, inst_valid_o,
    output imem_data, inst_ready_i
  );
endinterface

// File: rtl/ifetch_len.sv
// Combinational RISC-V length decode: compressed vs 32-bit, PC step, and
// detection of a 32-bit instruction cut off by the top of the memory window.
module ifetch_len
  import ifetch_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_BYTES = 1024
) (
  input  logic [31:0]     d,
  input  logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            is_c,
  output logic [2:0]      incr,
  output logic            at_top,
  output logic            trunc
);

  always_comb begin
    is_c   = (d[1:0] != ILEN_32);
    inst   = is_c ? {16'h0, d[15:0]} : d;
    incr   = is_c ? 3'd2 : 3'd4;
    // Only a halfword remains readable in the last two bytes of the window.
    at_top = (pc == XLEN'(MEM_BYTES - 2));
    trunc  = at_top && !is_c;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, issues one fetch per cycle, hands
// instructions to decode, follows redirects and halts on fetch faults.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              MEM_BYTES = 1024,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  ifetch_if.master        bus,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o
);

  localparam int AW = $clog2(MEM_BYTES);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            inst_c_q;
  logic            inst_vld_q;

  logic [31:0]     len_inst;
  logic            len_is_c;
  logic [2:0]      len_incr;
  logic            len_at_top;
  logic            len_trunc;
  logic            load;
  logic            fault_now;
  logic            unused_data_hi;

  ifetch_len #(
    .XLEN      (XLEN),
    .MEM_BYTES (MEM_BYTES)
  ) u_len (
    .d      (bus.imem_data[31:0]),
    .pc     (pc),
    .inst   (len_inst),
    .is_c   (len_is_c),
    .incr   (len_incr),
    .at_top (len_at_top),
    .trunc  (len_trunc)
  );

  assign unused_data_hi = ^bus.imem_data[63:32];

  // A fetch only happens when the output register is free or being drained.
  assign load      = (state == RUN) && !redirect_i && (!inst_vld_q || bus.inst_ready_i);
  assign fault_now = pc[0] || (pc >= XLEN'(MEM_BYTES)) || len_trunc;

  assign bus.imem_cs      = load;
  assign bus.imem_addr    = pc[AW-1:0];
  assign bus.imem_word    = len_at_top ? WORD_H : WORD_W;
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = inst_pc_q;
  assign bus.inst_c_o     = inst_c_q;
  assign bus.inst_valid_o = inst_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_c_q   <= 1'b0;
      inst_vld_q <= 1'b0;
      fault_o    <= 1'b0;
      fault_pc_o <= '0;
    end else begin
      fault_o <= 1'b0;
      if (redirect_i) begin
        state      <= RUN;
        pc         <= redirect_pc_i;
        inst_vld_q <= 1'b0;
      end else if (load) begin
        if (fault_now) begin
          state      <= HALT;
          inst_vld_q <= 1'b0;
          fault_o    <= 1'b1;
          fault_pc_o <= pc;
        end else begin
          inst_q     <= len_inst;
          inst_pc_q  <= pc;
          inst_c_q   <= len_is_c;
          inst_vld_q <= 1'b1;
          pc         <= pc + XLEN'(len_incr);
        end
      end
      // Neither redirect nor load means a stall (or HALT): everything holds.
    end
  end

endmodule
